serial_adder_ctrl: RTL

Bit-serial adder sequencer. It shares a single one-bit adder slice across all bits of a WIDTH-bit addition. The slice is two half-adder stages plus an OR for the carry. The block latches two operands on a start request and feeds the slice one bit per cycle, LSB first. It keeps the running carry in a flip-flop, shifts sum bits into a result register, and signals completion with a one-cycle done pulse. It sits between the team's gate-level adder cells and any requester that trades latency for area.

---
 rtl/serial_adder_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder slice, LSB first, one bit per cycle.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input for a-b (two's complement) operation.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // state | meaning
  // IDLE  | waiting for start; sum/c_out hold last result
  // RUN   | one operand bit pair through the slice per cycle
  // DONE  | result valid, done pulse, back to IDLE next edge
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             ha1_s, ha1_c, ha2_c;
  logic             s_bit, c_bit;
  logic             sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Two half-adder stages plus an OR for the carry.
  assign ha1_s = a_sh[0] ^ b_sh[0];
  assign ha1_c = a_sh[0] & b_sh[0];
  assign s_bit = ha1_s ^ carry;
  assign ha2_c = ha1_s & carry;
  assign c_bit = ha1_c | ha2_c;

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction reuses the adder: a + ~b + 1.
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{sub_sel}};
            carry <= sub_sel;
            cnt   <= '0;
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= {s_bit, acc[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_bit;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            sum   <= {s_bit, acc[WIDTH-1:1]};
            c_out <= c_bit;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
